// File: rtl/parking_pkg.sv
// parking_pkg: shared constants and the hour-dependent university capacity schedule.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package parking_pkg;

  localparam int HOUR_W        = 5;
  localparam int HOURS_PER_DAY = 24;

  // Default capacity plan of the original two-zone site.
  localparam int DEF_TOTAL_CAP    = 700;
  localparam int DEF_UNI_BASE     = 500;
  localparam int DEF_UNI_MIN      = 200;
  localparam int DEF_STEP         = 100;
  localparam int DEF_SHRINK_START = 13;

  // University zone capacity for a given hour. Evaluated in 32-bit signed
  // arithmetic so the subtraction can go negative before clamping to the floor.
  function automatic int uni_cap_at(input int hour,
                                    input int uni_base,
                                    input int uni_min,
                                    input int step,
                                    input int shrink_start);
    int cap;
    if (hour <= shrink_start) begin
      cap = uni_base;
    end else begin
      cap = uni_base - step * (hour - shrink_start);
      if (cap < uni_min) cap = uni_min;
    end
    return cap;
  endfunction

endpackage

// File: rtl/parking_zone_manager_if.sv
// parking_zone_manager_if: gate-side requests/responses, hour control and occupancy display bus.
// Latency: n/a (wiring only).
// Backpressure: none; every request gets a one-cycle ack or nack pulse.
// master: gate sensors / hour source / display side. slave: parking_zone_manager.
interface parking_zone_manager_if #(
  parameter int CNT_W = 10
);
  import parking_pkg::*;

  // Hour control
  logic              hour_tick;
  logic              set_hour_valid;
  logic [HOUR_W-1:0] set_hour;

  // Gate events
  logic entry_req;
  logic entry_uni;
  logic exit_req;
  logic exit_uni;

  // Registered responses
  logic entry_ack;
  logic entry_nack;
  logic exit_ack;
  logic exit_nack;

  // Status / display
  logic [HOUR_W-1:0] hour;
  logic              is_open;
  logic [CNT_W-1:0]  uni_parked;
  logic [CNT_W-1:0]  gen_parked;
  logic [CNT_W-1:0]  ovf_parked;
  logic [CNT_W-1:0]  uni_vacant;
  logic [CNT_W-1:0]  gen_vacant;
  logic              uni_has_space;
  logic              gen_has_space;

  modport master (
    output hour_tick, set_hour_valid, set_hour,
    output entry_req, entry_uni, exit_req, exit_uni,
    input  entry_ack, entry_nack, exit_ack, exit_nack,
    input  hour, is_open, uni_parked, gen_parked, ovf_parked,
    input  uni_vacant, gen_vacant, uni_has_space, gen_has_space
  );

  modport slave (
    input  hour_tick, set_hour_valid, set_hour,
    input  entry_req, entry_uni, exit_req, exit_uni,
    output entry_ack, entry_nack, exit_ack, exit_nack,
    output hour, is_open, uni_parked, gen_parked, ovf_parked,
    output uni_vacant, gen_vacant, uni_has_space, gen_has_space
  );

endinterface

// File: rtl/parking_hour_clock.sv
// parking_hour_clock: hour-of-day register with load, tick and 23->0 wrap; decodes opening hours.
// Latency: load/tick visible one cycle after the sampling edge; is_open is combinational from the hour.
// Backpressure: none; load has priority over tick, out-of-range loads are dropped.
// Ports: clk, reset (sync, active-high), i_hour_tick, i_set_hour_valid, i_set_hour -> o_hour, o_is_open.
module parking_hour_clock
  import parking_pkg::*;
#(
  parameter int OPEN_HOUR  = 8,
  parameter int CLOSE_HOUR = 24,
  parameter int RESET_HOUR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_hour_tick,
  input  logic              i_set_hour_valid,
  input  logic [HOUR_W-1:0] i_set_hour,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_is_open
);

  logic [HOUR_W-1:0] r_hour;
  int                w_hour_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hour <= HOUR_W'(RESET_HOUR);
    end else if (i_set_hour_valid) begin
      // An invalid load still wins over a tick; it simply leaves the hour alone.
      if (i_set_hour < HOUR_W'(HOURS_PER_DAY)) r_hour <= i_set_hour;
    end else if (i_hour_tick) begin
      if (r_hour == HOUR_W'(HOURS_PER_DAY - 1)) r_hour <= '0;
      else                                       r_hour <= r_hour + 1'b1;
    end
  end

  assign w_hour_int = int'(r_hour);
  assign o_hour     = r_hour;
  assign o_is_open  = (w_hour_int >= OPEN_HOUR) && (w_hour_int < CLOSE_HOUR);

endmodule

// File: rtl/parking_zone_manager.sv
// parking_zone_manager: two-zone car park admission with hour-dependent university capacity and overflow.
// Latency: request sampled at edge N -> ack/nack pulse and counter update visible after edge N.
// Backpressure: none; each sampled request gets exactly one ack or nack, refusals leave counters unchanged.
// Ports: clk, reset (sync, active-high), bus (slave modport: hour control, gate events, responses, status).
module parking_zone_manager
  import parking_pkg::*;
#(
  parameter int TOTAL_CAP    = DEF_TOTAL_CAP,
  parameter int UNI_BASE     = DEF_UNI_BASE,
  parameter int UNI_MIN      = DEF_UNI_MIN,
  parameter int STEP         = DEF_STEP,
  parameter int SHRINK_START = DEF_SHRINK_START,
  parameter int OPEN_HOUR    = 8,
  parameter int CLOSE_HOUR   = 24,
  parameter int UNI_OVERFLOW = 1,
  parameter int RESET_HOUR   = 0,
  parameter int CNT_W        = 10
) (
  input logic                   clk,
  input logic                   reset,
  parking_zone_manager_if.slave bus
);

  // Extra headroom so capacity-minus-occupancy never wraps.
  localparam int EW = CNT_W + 5;

  logic [HOUR_W-1:0] w_hour;
  logic              w_is_open;

  logic [CNT_W-1:0] r_uni, r_gen, r_ovf;
  logic             r_entry_ack, r_entry_nack, r_exit_ack, r_exit_nack;

  logic [EW-1:0] w_uni_cap, w_gen_cap, w_gen_used, w_uni_vac, w_gen_vac;
  logic          w_uni_has, w_gen_has;

  logic w_inc_uni, w_inc_ovf, w_inc_gen, w_entry_ok;
  logic w_dec_uni, w_dec_ovf, w_dec_gen, w_exit_ok;

  parking_hour_clock #(
    .OPEN_HOUR (OPEN_HOUR),
    .CLOSE_HOUR(CLOSE_HOUR),
    .RESET_HOUR(RESET_HOUR)
  ) u_hour_clock (
    .clk             (clk),
    .reset           (reset),
    .i_hour_tick     (bus.hour_tick),
    .i_set_hour_valid(bus.set_hour_valid),
    .i_set_hour      (bus.set_hour),
    .o_hour          (w_hour),
    .o_is_open       (w_is_open)
  );

  // Capacity and saturating vacancy, all from registered state.
  assign w_uni_cap  = EW'(uni_cap_at(int'(w_hour), UNI_BASE, UNI_MIN, STEP, SHRINK_START));
  assign w_gen_cap  = EW'(TOTAL_CAP) - w_uni_cap;
  assign w_gen_used = EW'(r_gen) + EW'(r_ovf);
  assign w_uni_vac  = (w_uni_cap > EW'(r_uni)) ? (w_uni_cap - EW'(r_uni)) : '0;
  assign w_gen_vac  = (w_gen_cap > w_gen_used) ? (w_gen_cap - w_gen_used) : '0;
  assign w_uni_has  = (w_uni_vac != '0);
  assign w_gen_has  = (w_gen_vac != '0);

  // Admission uses only pre-update counts, so a same-cycle exit never frees
  // a space for the entry sampled alongside it.
  always_comb begin
    w_inc_uni = 1'b0;
    w_inc_ovf = 1'b0;
    w_inc_gen = 1'b0;
    if (bus.entry_req && w_is_open) begin
      if (bus.entry_uni) begin
        if (w_uni_has)                            w_inc_uni = 1'b1;
        else if ((UNI_OVERFLOW != 0) && w_gen_has) w_inc_ovf = 1'b1;
      end else if (w_gen_has) begin
        w_inc_gen = 1'b1;
      end
    end
    w_entry_ok = w_inc_uni | w_inc_ovf | w_inc_gen;
  end

  // University exits drain overflow first, returning general spaces sooner.
  always_comb begin
    w_dec_uni = 1'b0;
    w_dec_ovf = 1'b0;
    w_dec_gen = 1'b0;
    if (bus.exit_req) begin
      if (bus.exit_uni) begin
        if (r_ovf != '0)      w_dec_ovf = 1'b1;
        else if (r_uni != '0) w_dec_uni = 1'b1;
      end else if (r_gen != '0) begin
        w_dec_gen = 1'b1;
      end
    end
    w_exit_ok = w_dec_uni | w_dec_ovf | w_dec_gen;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_uni        <= '0;
      r_gen        <= '0;
      r_ovf        <= '0;
      r_entry_ack  <= 1'b0;
      r_entry_nack <= 1'b0;
      r_exit_ack   <= 1'b0;
      r_exit_nack  <= 1'b0;
    end else begin
      r_uni        <= r_uni + CNT_W'(w_inc_uni) - CNT_W'(w_dec_uni);
      r_gen        <= r_gen + CNT_W'(w_inc_gen) - CNT_W'(w_dec_gen);
      r_ovf        <= r_ovf + CNT_W'(w_inc_ovf) - CNT_W'(w_dec_ovf);
      r_entry_ack  <= bus.entry_req &  w_entry_ok;
      r_entry_nack <= bus.entry_req & ~w_entry_ok;
      r_exit_ack   <= bus.exit_req  &  w_exit_ok;
      r_exit_nack  <= bus.exit_req  & ~w_exit_ok;
    end
  end

  assign bus.entry_ack     = r_entry_ack;
  assign bus.entry_nack    = r_entry_nack;
  assign bus.exit_ack      = r_exit_ack;
  assign bus.exit_nack     = r_exit_nack;
  assign bus.hour          = w_hour;
  assign bus.is_open       = w_is_open;
  assign bus.uni_parked    = r_uni;
  assign bus.gen_parked    = r_gen;
  assign bus.ovf_parked    = r_ovf;
  assign bus.uni_vacant    = CNT_W'(w_uni_vac);
  assign bus.gen_vacant    = CNT_W'(w_gen_vac);
  assign bus.uni_has_space = w_uni_has;
  assign bus.gen_has_space = w_gen_has;

endmodule

// File: tb/tb_parking_zone_manager.sv
// tb_parking_zone_manager: directed scenarios plus a random run against a cars-and-spaces model.
// Latency: each step drives one cycle of requests and checks the responses after the next edge.
// Backpressure: n/a.
module tb_parking_zone_manager;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  parking_zone_manager_if #(.CNT_W(10)) bus ();

  parking_zone_manager u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Model state: what the car park should look like.
  int m_hour, m_uni, m_gen, m_ovf;
  bit m_e_ack, m_e_nack, m_x_ack, m_x_nack;
  int ack_cnt, nack_cnt;

  // Capacity plan of the site, written as a lookup by hour.
  function automatic int uni_space(input int h);
    case (h)
      14:      return 400;
      15:      return 300;
      default: return (h >= 16) ? 200 : 500;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int uv, gv;
    uv = sat(uni_space(m_hour) - m_uni);
    gv = sat(700 - uni_space(m_hour) - m_gen - m_ovf);
    chk("entry_ack",  32'(bus.entry_ack),  32'(m_e_ack));
    chk("entry_nack", 32'(bus.entry_nack), 32'(m_e_nack));
    chk("exit_ack",   32'(bus.exit_ack),   32'(m_x_ack));
    chk("exit_nack",  32'(bus.exit_nack),  32'(m_x_nack));
    chk("hour",       32'(bus.hour),       m_hour);
    chk("is_open",    32'(bus.is_open),    (m_hour >= 8 && m_hour < 24) ? 1 : 0);
    chk("uni_parked", 32'(bus.uni_parked), m_uni);
    chk("gen_parked", 32'(bus.gen_parked), m_gen);
    chk("ovf_parked", 32'(bus.ovf_parked), m_ovf);
    chk("uni_vacant", 32'(bus.uni_vacant), uv);
    chk("gen_vacant", 32'(bus.gen_vacant), gv);
    chk("uni_has",    32'(bus.uni_has_space), (uv != 0) ? 1 : 0);
    chk("gen_has",    32'(bus.gen_has_space), (gv != 0) ? 1 : 0);
  endtask

  // One clock of stimulus; model decides from the state before the edge.
  task automatic step(input bit rst, input bit tick, input bit setv, input int seth,
                      input bit ereq, input bit euni, input bit xreq, input bit xuni);
    bit open;
    int uv, gv;
    int d_uni, d_gen, d_ovf;
    reset              = rst;
    bus.hour_tick      = tick;
    bus.set_hour_valid = setv;
    bus.set_hour       = 5'(seth);
    bus.entry_req      = ereq;
    bus.entry_uni      = euni;
    bus.exit_req       = xreq;
    bus.exit_uni       = xuni;
    m_e_ack = 0; m_e_nack = 0; m_x_ack = 0; m_x_nack = 0;
    if (rst) begin
      m_hour = 0; m_uni = 0; m_gen = 0; m_ovf = 0;
    end else begin
      open  = (m_hour >= 8 && m_hour < 24);
      uv    = sat(uni_space(m_hour) - m_uni);
      gv    = sat(700 - uni_space(m_hour) - m_gen - m_ovf);
      d_uni = 0; d_gen = 0; d_ovf = 0;
      if (ereq) begin
        if (open && euni && uv > 0)       begin d_uni += 1; m_e_ack = 1; end
        else if (open && euni && gv > 0)  begin d_ovf += 1; m_e_ack = 1; end
        else if (open && !euni && gv > 0) begin d_gen += 1; m_e_ack = 1; end
        else m_e_nack = 1;
      end
      if (xreq) begin
        if (xuni && m_ovf > 0)       begin d_ovf -= 1; m_x_ack = 1; end
        else if (xuni && m_uni > 0)  begin d_uni -= 1; m_x_ack = 1; end
        else if (!xuni && m_gen > 0) begin d_gen -= 1; m_x_ack = 1; end
        else m_x_nack = 1;
      end
      m_uni += d_uni; m_gen += d_gen; m_ovf += d_ovf;
      if (setv) begin
        if (seth < 24) m_hour = seth;
      end else if (tick) begin
        m_hour = (m_hour + 1) % 24;
      end
    end
    @(posedge clk);
    #1;
    reset = 0; bus.hour_tick = 0; bus.set_hour_valid = 0; bus.set_hour = '0;
    bus.entry_req = 0; bus.entry_uni = 0; bus.exit_req = 0; bus.exit_uni = 0;
    if (m_e_ack) ack_cnt++;
    if (m_e_nack) nack_cnt++;
    check_all();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_hr(input int h);
    step(0, 0, 1, h, 0, 0, 0, 0);
  endtask

  initial begin
    m_hour = 0; m_uni = 0; m_gen = 0; m_ovf = 0;
    reset = 1;
    bus.hour_tick = 0; bus.set_hour_valid = 0; bus.set_hour = '0;
    bus.entry_req = 0; bus.entry_uni = 0; bus.exit_req = 0; bus.exit_uni = 0;
    @(posedge clk); #1;

    // Reset state with defaults.
    do_reset();
    chk("rst_uni_vacant", 32'(bus.uni_vacant), 500);
    chk("rst_gen_vacant", 32'(bus.gen_vacant), 200);

    // Closed at hour 7.
    set_hr(7);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("closed_nack", 32'(bus.entry_nack), 1);

    // Open at 8, one car into each zone.
    set_hr(8);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    chk("tp_uvac", 32'(bus.uni_vacant), 499);
    chk("tp_gvac", 32'(bus.gen_vacant), 199);

    // Fill university zone and spill one into general.
    do_reset();
    set_hr(8);
    for (int i = 0; i < 501; i++) step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("fill_uni", 32'(bus.uni_parked), 500);
    chk("fill_ovf", 32'(bus.ovf_parked), 1);
    ack_cnt = 0; nack_cnt = 0;
    for (int i = 0; i < 200; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    chk("gen_acks",  ack_cnt,  199);
    chk("gen_nacks", nack_cnt, 1);
    chk("gen_full",  32'(bus.gen_vacant), 0);

    // Afternoon shrink: university cap 200, general cap 500.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("h16_uvac", 32'(bus.uni_vacant), 0);
    chk("h16_gvac", 32'(bus.gen_vacant), 300);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("h16_ovf", 32'(bus.ovf_parked), 2);

    // Both zones full, simultaneous university entry and exit: freed space not credited.
    do_reset();
    set_hr(8);
    for (int i = 0; i < 500; i++) step(0, 0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 200; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 1);
    chk("sim_nack", 32'(bus.entry_nack), 1);
    chk("sim_uni",  32'(bus.uni_parked), 499);

    // One university car, closed hour: entry refused, exit allowed.
    do_reset();
    set_hr(8);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    set_hr(23);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 1);
    chk("closed_exit_uni", 32'(bus.uni_parked), 0);

    // Exits on empty, invalid hour load, set-over-tick priority.
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 30, 0, 0, 0, 0);
    step(0, 1, 1, 10, 0, 0, 0, 0);

    // Reset wins over requests in the same cycle.
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 1, 0);

    // Random traffic.
    set_hr(8);
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 999) == 0,
           $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 2,
           int'($urandom_range(0, 31)),
           $urandom_range(0, 99) < 80,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
